// File: rtl/lpf_sched_pkg.sv
// Shared sizing for the low-pass scheduler: channel count, window depth,
// sample width and the derived sum / channel-index widths.
package lpf_pkg;
  localparam int NCH  = 4;
  localparam int TAPS = 8;
  localparam int DW   = 18;
  localparam int SUMW = DW + 3;
  localparam int CHW  = $clog2(NCH);
endpackage

// File: rtl/lpf_sched_if.sv
// Request/result bundle for lpf_sched. master = sample producer and result
// consumer, slave = the scheduler itself.
interface lpf_sched_if;
  import lpf_pkg::*;

  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    flush;
  logic              out_valid;
  logic              out_ready;
  logic [CHW-1:0]    out_ch;
  logic [SUMW-1:0]   out_sum;
  logic [DW-1:0]     out_data;
  logic              out_warm;

  modport master (
    output req_valid, req_data, flush, out_ready,
    input  req_ready, out_valid, out_ch, out_sum, out_data, out_warm
  );

  modport slave (
    input  req_valid, req_data, flush, out_ready,
    output req_ready, out_valid, out_ch, out_sum, out_data, out_warm
  );
endinterface

// File: rtl/lpf_sched_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted channel,
// at most one grant, pointer moves only when a grant is issued.
module rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gidx
);
  logic [W-1:0] last;
  logic [W-1:0] idx;
  logic         found;

  // first requester after 'last', wrapping; nothing granted when disabled
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(last) + k) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = idx;
        found    = 1'b1;
      end
    end
  end

  // reset parks the pointer on N-1 so channel 0 wins first
  always_ff @(posedge clk) begin
    if (rst)        last <= W'(N - 1);
    else if (found) last <= gidx;
  end
endmodule

// File: rtl/lpf_sched.sv
// Time-shared moving-sum filter. One arbitrated sample per cycle enters
// stage A; the following cycle updates that channel's window (history,
// pointer, sum, fill count) and loads the result register in one step.
module lpf_sched #(
  parameter int NCH  = lpf_pkg::NCH,
  parameter int TAPS = lpf_pkg::TAPS,
  parameter int DW   = lpf_pkg::DW
) (
  input logic        clk,
  input logic        rst,
  lpf_sched_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int PW = $clog2(TAPS);
  localparam int FW = $clog2(TAPS + 1);
  localparam int SW = DW + 3;

  logic           stall, en;
  logic [NCH-1:0] gnt;
  logic [CW-1:0]  gidx;
  logic [DW-1:0]  sel_data;

  logic           a_vld;
  logic [CW-1:0]  a_ch;
  logic [DW-1:0]  a_data;

  logic [DW-1:0]  hist [NCH][TAPS];
  logic [PW-1:0]  wp   [NCH];
  logic [SW-1:0]  sum  [NCH];
  logic [FW-1:0]  cnt  [NCH];

  logic [DW-1:0]  oldest;
  logic [SW-1:0]  new_sum;
  logic [FW-1:0]  new_cnt;
  logic           b_fire;

  assign stall = bus.out_valid & ~bus.out_ready;
  assign en    = ~stall & ~rst;

  rr_arb #(.N(NCH), .W(CW)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.req_valid & ~bus.flush),
    .en   (en),
    .gnt  (gnt),
    .gidx (gidx)
  );

  assign bus.req_ready = gnt;

  // pick the granted channel's sample off the flat bus
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt[i]) sel_data = bus.req_data[i*DW +: DW];
  end

  // window update for the stage A sample; sum never goes below oldest
  always_comb begin
    oldest  = hist[a_ch][wp[a_ch]];
    new_sum = sum[a_ch] - SW'(oldest) + SW'(a_data);
    new_cnt = (cnt[a_ch] == FW'(TAPS)) ? cnt[a_ch] : cnt[a_ch] + 1'b1;
    b_fire  = a_vld & ~stall & ~bus.flush[a_ch];
  end

  // stage A: capture accepted sample; a flush while held kills it
  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld  <= 1'b0;
      a_ch   <= '0;
      a_data <= '0;
    end else if (!stall) begin
      a_vld  <= |gnt;
      a_ch   <= gidx;
      a_data <= sel_data;
    end else if (bus.flush[a_ch]) begin
      a_vld  <= 1'b0;
    end
  end

  // per-channel window state; flush wins over a same-cycle update
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst || bus.flush[i]) begin
        for (int t = 0; t < TAPS; t++) hist[i][t] <= '0;
        wp[i]  <= '0;
        sum[i] <= '0;
        cnt[i] <= '0;
      end else if (b_fire && a_ch == CW'(i)) begin
        hist[i][wp[i]] <= a_data;
        wp[i]          <= wp[i] + 1'b1;
        sum[i]         <= new_sum;
        cnt[i]         <= new_cnt;
      end
    end
  end

  // result register: holds under backpressure, flush does not touch it
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_sum   <= '0;
      bus.out_warm  <= 1'b0;
    end else if (!stall) begin
      bus.out_valid <= b_fire;
      if (b_fire) begin
        bus.out_ch   <= a_ch;
        bus.out_sum  <= new_sum;
        bus.out_warm <= (new_cnt == FW'(TAPS));
      end
    end
  end

  assign bus.out_data = bus.out_sum[SW-1:3];
endmodule

// File: tb/tb_lpf_sched.sv
// Bench for lpf_sched: per-channel sample queues feed the bus, a negedge
// monitor predicts grants and window sums and checks every delivered result.
module tb_lpf_sched;
  import lpf_pkg::*;

  typedef struct {
    int ch;
    int sum;
    int data;
    bit warm;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lpf_sched_if bus();

  lpf_sched #(.NCH(NCH), .TAPS(TAPS), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  res_t sb[$];
  res_t log_q[$];
  int   src[NCH][$];
  int   hq[NCH][$];
  bit [NCH-1:0] xfer;
  bit [NCH-1:0] drop;
  int   rr_last;

  logic [NCH-1:0] eg;
  int   gsel, c, s;
  bit   stall_s, have_snap;
  res_t e, snap, got;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout want completion", name);
  endtask

  function automatic bit busy();
    for (int i = 0; i < NCH; i++) if (src[i].size() > 0) return 1'b1;
    return (sb.size() > 0) || (bus.out_valid === 1'b1);
  endfunction

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (busy() && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) fail_now(name);
    repeat (2) @(negedge clk);
  endtask

  // driver: retire transferred samples, present each queue head
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (xfer[i] && src[i].size() > 0) void'(src[i].pop_front());
      bus.req_valid[i] = (src[i].size() > 0);
      bus.req_data[i*DW +: DW] = (src[i].size() > 0) ? DW'(src[i][0]) : '0;
    end
    xfer = '0;
  end

  // monitor: hold checks, scoreboard pops, grant prediction, model update
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", bus.req_ready, 0);
      sb.delete();
      for (int i = 0; i < NCH; i++) hq[i].delete();
      rr_last   = NCH - 1;
      xfer      = '0;
      have_snap = 1'b0;
    end else begin
      stall_s = bus.out_valid && !bus.out_ready;
      if (stall_s && have_snap) begin
        chk("hold_ch",   bus.out_ch,   snap.ch);
        chk("hold_sum",  bus.out_sum,  snap.sum);
        chk("hold_warm", bus.out_warm, snap.warm);
      end
      if (stall_s) begin
        snap.ch   = int'(bus.out_ch);
        snap.sum  = int'(bus.out_sum);
        snap.warm = bus.out_warm;
        have_snap = 1'b1;
      end else begin
        have_snap = 1'b0;
      end

      if (bus.out_valid && bus.out_ready) begin
        got.ch   = int'(bus.out_ch);
        got.sum  = int'(bus.out_sum);
        got.data = int'(bus.out_data);
        got.warm = bus.out_warm;
        log_q.push_back(got);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_result: got ch %0d sum %0h want none", got.ch, got.sum);
        end else begin
          e = sb.pop_front();
          chk("out_ch",   bus.out_ch,   e.ch);
          chk("out_sum",  bus.out_sum,  e.sum);
          chk("out_data", bus.out_data, e.data);
          chk("out_warm", bus.out_warm, e.warm);
        end
      end

      for (int i = 0; i < NCH; i++) if (bus.flush[i]) hq[i].delete();

      eg   = '0;
      gsel = 0;
      if (!stall_s) begin
        for (int k = 1; k <= NCH; k++) begin
          c = (rr_last + k) % NCH;
          if (eg == '0 && bus.req_valid[c] && !bus.flush[c]) begin
            eg[c] = 1'b1;
            gsel  = c;
          end
        end
      end
      chk("grant", bus.req_ready, eg);

      if (eg != '0) begin
        rr_last    = gsel;
        xfer[gsel] = 1'b1;
        if (drop[gsel]) begin
          drop[gsel] = 1'b0;
        end else begin
          hq[gsel].push_back(src[gsel][0]);
          if (hq[gsel].size() > TAPS) void'(hq[gsel].pop_front());
          s = 0;
          foreach (hq[gsel][j]) s += hq[gsel][j];
          e.ch   = gsel;
          e.sum  = s;
          e.data = s / 8;
          e.warm = (hq[gsel].size() == TAPS);
          sb.push_back(e);
        end
      end
    end
  end

  int t0, t1, k;
  int exp1[10] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52};

  initial begin
    rst           = 1'b1;
    bus.flush     = '0;
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    drop          = '0;
    xfer          = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_ch",    bus.out_ch,    0);
    chk("rst_out_sum",   bus.out_sum,   0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_warm",  bus.out_warm,  0);
    @(posedge clk); #1 rst = 1'b0;

    // channel 0 alone, 1..10 back to back
    log_q.delete();
    for (int v = 1; v <= 10; v++) src[0].push_back(v);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(bus.req_valid[0] && bus.req_ready[0]) && k < 50);
    t0 = cyc;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!bus.out_valid && k < 50);
    t1 = cyc;
    chk("first_latency", t1 - t0, 2);
    wait_idle("ch0_stream", 200);
    chk("ch0_count", log_q.size(), 10);
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      chk("ch0_sum_tbl",  log_q[i].sum,  exp1[i]);
      chk("ch0_warm_tbl", log_q[i].warm, (i >= 7));
    end

    // channel 1 full-scale samples
    log_q.delete();
    for (int v = 0; v < 8; v++) src[1].push_back('h3FFFF);
    wait_idle("ch1_max", 200);
    if (log_q.size() == 8) begin
      chk("max_sum",  log_q[7].sum,  'h1FFFF8);
      chk("max_data", log_q[7].data, 'h3FFFF);
      chk("max_warm", log_q[7].warm, 1);
    end else chk("max_count", log_q.size(), 8);

    // all channels continuously valid
    for (int i = 0; i < NCH; i++)
      for (int v = 0; v < 6; v++) src[i].push_back(i * 100 + v * 7 + 3);
    wait_idle("all_ch", 400);

    // backpressure for 5 cycles mid-stream
    log_q.delete();
    for (int v = 0; v < 6; v++) begin
      src[0].push_back(v + 11);
      src[3].push_back(v * 3 + 50);
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle("stall", 300);
    chk("stall_count", log_q.size(), 12);

    // flush channel 2 the cycle after its transfer
    log_q.delete();
    drop[2] = 1'b1;
    src[2].push_back(5);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(bus.req_valid[2] && bus.req_ready[2]) && k < 50);
    if (k >= 50) fail_now("flush_xfer");
    @(posedge clk); #1 bus.flush[2] = 1'b1;
    @(posedge clk); #1 bus.flush[2] = 1'b0;
    src[2].push_back(7);
    wait_idle("flush", 200);
    chk("flush_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("flush_ch",   log_q[0].ch,   2);
      chk("flush_sum",  log_q[0].sum,  7);
      chk("flush_warm", log_q[0].warm, 0);
    end

    // reset mid-stream, then channel 0 must win first
    for (int v = 0; v < 10; v++) begin
      src[0].push_back(v + 1);
      src[1].push_back(v + 20);
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ch",    bus.out_ch,    0);
    chk("mid_rst_sum",   bus.out_sum,   0);
    chk("mid_rst_data",  bus.out_data,  0);
    chk("mid_rst_warm",  bus.out_warm,  0);
    @(posedge clk); #1 rst = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (bus.req_ready == '0 && k < 50);
    chk("post_rst_grant", bus.req_ready, 1);
    wait_idle("post_rst", 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lpf_sched.md
LPF_SCHED -- requirements
Module: lpf_sched

Interface
REQ-001 Parameter NCH, default 4, is the number of requesting channels.
REQ-002 Parameter TAPS, default 8, is the moving-sum window depth (power of two).
REQ-003 Parameter DW, default 18, is the sample width (unsigned).
REQ-004 clk  in  1  the single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  NCH  per-channel sample-offered flag.
REQ-007 req_data  in  NCH*DW  per-channel sample; channel i occupies bits [i*DW +: DW].
REQ-008 req_ready  out  NCH  one-hot grant; a sample transfers when req_valid[i] & req_ready[i].
REQ-009 flush  in  NCH  per-channel clear of window state.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  downstream accepts result.
REQ-012 out_ch  out  clog2(NCH)  channel of the current result.
REQ-013 out_sum  out  DW+3  full window sum.
REQ-014 out_data  out  DW  window average, out_sum[DW+2:3].
REQ-015 out_warm  out  1  result's channel had at least TAPS samples accepted.

Function
REQ-016 The block SHALL time-share one sliding-sum datapath among NCH channels: per channel a TAPS-deep sample history, a write pointer, a running sum and a fill counter.
REQ-017 The arbiter SHALL be round-robin: search begins at the channel after the last granted one; at most one req_ready bit is high per cycle; req_ready is combinational from req_valid, pointer, stall and flush.
REQ-018 The pointer SHALL advance only on an actual transfer; a lone requester SHALL be granted every unstalled cycle.
REQ-019 Pipeline: stage A registers the accepted sample and channel; stage B, one cycle later, reads the oldest history entry, writes the new sample at the write pointer, advances the pointer mod TAPS, and sets sum := sum - oldest + new.
REQ-020 The output register SHALL load from stage B, so out_valid rises 2 cycles after transfer; back-to-back same-channel samples SHALL produce correct consecutive sums with no bubble.
REQ-021 Sum width DW+3 SHALL never overflow; subtraction precedes no truncation; out_data is floor(sum/8).
REQ-022 The fill counter SHALL saturate at TAPS; out_warm = counter value after the update equals TAPS. Pre-warm results use zero-filled history.
REQ-023 Stall: when out_valid & !out_ready, out_* SHALL hold, stages A/B SHALL hold, and req_ready SHALL be all zero.
REQ-024 flush[i] SHALL, in the same cycle, clear channel i history, sum, pointer and counter; req_ready[i] SHALL be 0 that cycle; any stage A/B sample of channel i SHALL be discarded (no out_valid for it).
REQ-025 A flushed channel already in the output register SHALL still be delivered.

Reset
REQ-026 On rst: out_valid=0, out_ch=0, out_sum=0, out_data=0, out_warm=0, req_ready=0, all histories, sums, pointers, counters cleared, stages empty, round-robin pointer at channel NCH-1 (so channel 0 has first priority).
REQ-027 rst SHALL override flush, stall and any transfer in the same cycle.

Structure
REQ-028 Package lpf_pkg SHALL hold NCH, TAPS, DW, SUMW=DW+3 and the channel-index width.
REQ-029 The round-robin arbiter SHALL be a sub-module rr_arb (request vector, enable, grant vector, pointer update).

Verification
REQ-030 Channel 0 alone sends 1..10 back-to-back -> out_sum 1,3,6,10,15,21,28,36,44,52; out_warm first high on the 8th; first out_valid 2 cycles after first transfer.
REQ-031 All 4 channels valid continuously -> grants 0,1,2,3,0,... one per cycle; each channel's sums independent and correct.
REQ-032 Channel 1 sends 8 x 0x3FFFF -> out_sum 0x1FFFF8, out_data 0x3FFFF, no overflow.
REQ-033 out_ready low 5 cycles during a stream -> outputs held, req_ready all 0, no sample lost or duplicated after release.
REQ-034 flush[2] asserted the cycle after a channel-2 transfer -> no result for that sample; next channel-2 sample 7 -> out_sum 7, out_warm 0.
REQ-035 rst pulsed mid-stream -> all outputs 0 next cycle; first post-reset grant to channel 0.
